// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control sequencer for the multicycle i281 CPU. Steps each instruction
//   through FETCH / DECODE / EXEC / MEM / WB and issues the per-cycle strobes
//   that the datapath registers consume. A low run freezes the sequencer in
//   lock-step with the PC register.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous active-low reset (overrides run)
//   run          global enable; 0 freezes state, counter and all strobes
//   opcode       IR[15:12], valid from DECODE onward
//   cond         IR[9:8], branch condition field
//   flag_z/n/c/o zero / negative / carry / overflow flags
//   ir_load      load IR from instruction memory at current PC (FETCH)
//   reg_write    register-file write enable (WB)
//   flags_write  flag register write enable (EXEC)
//   dmem_write   data-memory write enable (MEM)
//   c3           PC load strobe, asserted once per instruction in WB
//   pc_sel       next-PC select: 0 = PC+1, 1 = PC+1+offset
//   state        current state encoding
//   instr_count  retired instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic [1:0]       cond,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             flag_c,
    input  logic             flag_o,
    output logic             ir_load,
    output logic             reg_write,
    output logic             flags_write,
    output logic             dmem_write,
    output logic             c3,
    output logic             pc_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   active;

    // Opcodes 0x8..0xB are the load/store class that needs a MEM cycle.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    // NOOP, JUMP and BRANCH skip EXEC and MEM entirely.
    function automatic logic is_short_op(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'hE) || (op == 4'hF);
    endfunction

    function automatic logic is_flag_op(input logic [3:0] op);
        return (op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD});
    endfunction

    function automatic logic is_reg_op(input logic [3:0] op);
        return (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                           4'h7, 4'h8, 4'h9, 4'hC});
    endfunction

    function automatic logic branch_taken(input logic [1:0] c,
                                          input logic       z,
                                          input logic       n,
                                          input logic       cy,
                                          input logic       o);
        logic t;
        case (c)
            2'b00:   t = cy;
            2'b01:   t = z;
            2'b10:   t = !z && (n == o);
            default: t = (n == o);
        endcase
        return t;
    endfunction

    assign active = run && reset;
    assign state  = state_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= FETCH;
            instr_count <= '0;
        end else if (run) begin
            state_q <= state_d;
            if (state_q == WB)
                instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Strobes are gated by active so a frozen or resetting cycle never
    // fires a datapath write; the held state replays them once run returns.
    always_comb begin
        state_d     = FETCH;
        ir_load     = 1'b0;
        reg_write   = 1'b0;
        flags_write = 1'b0;
        dmem_write  = 1'b0;
        c3          = 1'b0;
        pc_sel      = 1'b0;
        case (state_q)
            FETCH: begin
                ir_load = active;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = is_short_op(opcode) ? WB : EXEC;
            end
            EXEC: begin
                flags_write = active && is_flag_op(opcode);
                state_d     = is_mem_op(opcode) ? MEM : WB;
            end
            MEM: begin
                dmem_write = active && (opcode == 4'hA || opcode == 4'hB);
                state_d    = WB;
            end
            WB: begin
                c3        = active;
                reg_write = active && is_reg_op(opcode);
                pc_sel    = active && ((opcode == 4'hE) ||
                            (opcode == 4'hF &&
                             branch_taken(cond, flag_z, flag_n, flag_c, flag_o)));
                state_d   = FETCH;
            end
            default: begin
                // Illegal codes 5..7 recover to FETCH with no strobes.
                state_d = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CW = 8;   // narrow counter so wrap-around is reachable quickly

    logic          clock = 1'b0;
    logic          reset, run;
    logic [3:0]    opcode;
    logic [1:0]    cond;
    logic          flag_z, flag_n, flag_c, flag_o;
    logic          ir_load, reg_write, flags_write, dmem_write, c3, pc_sel;
    logic [2:0]    state;
    logic [CW-1:0] instr_count;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run(run), .opcode(opcode), .cond(cond),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_o(flag_o),
        .ir_load(ir_load), .reg_write(reg_write), .flags_write(flags_write),
        .dmem_write(dmem_write), .c3(c3), .pc_sel(pc_sel), .state(state),
        .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]    st;
        logic [5:0]    stb;   // ir_load, reg_write, flags_write, dmem_write, c3, pc_sel
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;
    int   m_cnt  = 0;   // reference retired-instruction count

    // ---------------- reference model (instruction level) ----------------
    function automatic int cpi(input logic [3:0] op);
        if (op == 4'h0 || op == 4'hE || op == 4'hF) return 3;
        if (op >= 4'h8 && op <= 4'hB)               return 5;
        return 4;
    endfunction

    function automatic int phase_state(input int len, input int idx);
        int s3[3] = '{0, 1, 4};
        int s4[4] = '{0, 1, 2, 4};
        int s5[5] = '{0, 1, 2, 3, 4};
        if (len == 3) return s3[idx];
        if (len == 4) return s4[idx];
        return s5[idx];
    endfunction

    function automatic logic [5:0] strobes(input int s, input logic [3:0] op,
                                           input logic [1:0] cd,
                                           input logic z, input logic n,
                                           input logic c, input logic o);
        logic il, rw, fw, dw, pc, ps, taken;
        il = (s == 0);
        fw = (s == 2) && (op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD});
        dw = (s == 3) && (op == 4'hA || op == 4'hB);
        pc = (s == 4);
        rw = (s == 4) && !(op inside {4'h0, 4'hA, 4'hB, 4'hD, 4'hE, 4'hF});
        if      (cd == 2'd0) taken = c;
        else if (cd == 2'd1) taken = z;
        else if (cd == 2'd2) taken = (z == 1'b0) && (n == o);
        else                 taken = (n == o);
        ps = (s == 4) && (op == 4'hE || (op == 4'hF && taken));
        return {il, rw, fw, dw, pc, ps};
    endfunction

    // Drive one cycle: inputs just after the rising edge, expectation queued,
    // then advance the model count across the edge.
    task automatic drive_cycle(input logic r_n, input logic rn, input int s,
                               input logic [3:0] op, input logic [1:0] cd,
                               input logic [3:0] f);
        exp_t e;
        reset = r_n; run = rn; opcode = op; cond = cd;
        {flag_z, flag_n, flag_c, flag_o} = f;
        e.st  = 3'(s);
        e.stb = (rn && r_n) ? strobes(s, op, cd, f[3], f[2], f[1], f[0]) : 6'd0;
        e.cnt = CW'(m_cnt);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        if (!r_n)                 m_cnt = 0;
        else if (rn && s == 4)    m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    // One instruction; optional freeze before phase frz_idx, optional reset at rst_idx.
    task automatic do_instr(input logic [3:0] op, input logic [1:0] cd,
                            input bit fix_f, input logic [3:0] ff,
                            input int frz_idx, input int frz_len, input int rst_idx);
        int len = cpi(op);
        logic [3:0] f;
        for (int i = 0; i < len; i++) begin
            int s = phase_state(len, i);
            if (i == frz_idx)
                for (int k = 0; k < frz_len; k++) begin
                    f = fix_f ? ff : 4'($urandom_range(0, 15));
                    drive_cycle(1'b1, 1'b0, s, op, cd, f);
                end
            f = fix_f ? ff : 4'($urandom_range(0, 15));
            if (i == rst_idx) begin
                drive_cycle(1'b0, 1'($urandom_range(0, 1)), s, op, cd, f);
                return;
            end
            drive_cycle(1'b1, 1'b1, s, op, cd, f);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a.st  = state;
            a.stb = {ir_load, reg_write, flags_write, dmem_write, c3, pc_sel};
            a.cnt = instr_count;
            checks++;
            if (a === e) passes++;
            else $display("FAIL cycle %0d: state/strobes/count got st=%0d stb=%b cnt=%0h, expected st=%0d stb=%b cnt=%0h",
                          cyc, a.st, a.stb, a.cnt, e.st, e.stb, e.cnt);
        end
    end

    initial begin
        int budget;
        reset = 1'b0; run = 1'b1; opcode = 4'h0; cond = 2'd0;
        {flag_z, flag_n, flag_c, flag_o} = 4'h0;
        @(posedge clock);
        #1;
        // second reset cycle is checked: FETCH, count 0, no strobes
        drive_cycle(1'b0, 1'b1, 0, 4'h0, 2'd0, 4'h0);

        // directed cases (flags vector is {z,n,c,o})
        do_instr(4'h0, 2'd0, 1'b0, 4'h0, -1, 0, -1);          // NOOP
        do_instr(4'h4, 2'd0, 1'b0, 4'h0, -1, 0, -1);          // ADD
        do_instr(4'hA, 2'd0, 1'b0, 4'h0, -1, 0, -1);          // STORE
        do_instr(4'hF, 2'd2, 1'b1, 4'b0101, -1, 0, -1);       // BRANCH taken
        do_instr(4'hF, 2'd2, 1'b1, 4'b1101, -1, 0, -1);       // BRANCH not taken
        do_instr(4'hE, 2'd0, 1'b0, 4'h0, -1, 0, -1);          // JUMP
        do_instr(4'h4, 2'd0, 1'b0, 4'h0, 2, 3, -1);           // ADD frozen in EXEC
        do_instr(4'hB, 2'd0, 1'b0, 4'h0, -1, 0, 3);           // STOREF reset in MEM
        do_instr(4'h9, 2'd0, 1'b0, 4'h0, -1, 0, -1);          // LOAD after reset

        // randomized instruction stream with freezes and occasional resets
        for (int n = 0; n < 150; n++) begin
            logic [3:0] op = 4'($urandom_range(0, 15));
            int len = cpi(op);
            int fi  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            int ri  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            do_instr(op, 2'($urandom_range(0, 3)), 1'b0, 4'h0, fi,
                     int'($urandom_range(1, 3)), ri);
        end

        // counter wrap: retire enough NOOPs to pass 2^CW-1 -> 0
        for (int n = 0; n < (1 << CW) + 4; n++)
            do_instr(4'h0, 2'd0, 1'b0, 4'h0, -1, 0, -1);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clock);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
